// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/decoder pair: the decoder state
// type and the nominal PWM period used by both sides of the link.
package pwm_pkg;

    localparam int PWM_INTERVAL_DEFAULT = 1200;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } pwm_state_e;

endpackage : pwm_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PWM line into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: first flop may go metastable, second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/pwm_decoder.sv
// Measures high time and rise-to-rise period of an asynchronous PWM line and
// flags a static (stuck) line once no rising edge is seen for TIMEOUT cycles.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int  PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
    parameter int  TIMEOUT      = 2 * PWM_INTERVAL,
    localparam int W            = $clog2(PWM_INTERVAL),
    localparam int PW           = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    output logic [W-1:0]  duty,
    output logic [PW-1:0] period,
    output logic          sample_valid,
    output logic          locked,
    output logic          stuck
);

    localparam logic [PW-1:0] TIMEOUT_C = PW'(TIMEOUT);
    localparam logic [PW-1:0] ONE_C     = PW'(1);
    localparam logic [W-1:0]  DUTY_MAX  = {W{1'b1}};
    localparam logic [W-1:0]  DUTY_FULL = (PWM_INTERVAL >= (1 << W)) ? DUTY_MAX : W'(PWM_INTERVAL);

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] value);
        if (value >= TIMEOUT_C) begin
            return TIMEOUT_C;
        end else begin
            return value + ONE_C;
        end
    endfunction

    function automatic logic [W-1:0] clamp_duty(input logic [PW-1:0] cnt);
        if (cnt > PW'(DUTY_MAX)) begin
            return DUTY_MAX;
        end else begin
            return W'(cnt);
        end
    endfunction

    logic          s2_s;
    logic          s3_q;
    logic          rise_s;
    logic          fall_s;
    logic          timeout_s;

    pwm_state_e    state_q, state_d;
    logic [PW-1:0] period_cnt_q, period_cnt_d;
    logic [PW-1:0] high_cnt_q, high_cnt_d;
    logic [W-1:0]  duty_q, duty_d;
    logic [PW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          locked_q, locked_d;
    logic          stuck_q, stuck_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pwm_in),
        .q_o   (s2_s)
    );

    assign rise_s    = s2_s & ~s3_q;
    assign fall_s    = ~s2_s & s3_q;
    // A rise on the timeout cycle is a legal (long) period, not a stuck line.
    assign timeout_s = (period_cnt_q == TIMEOUT_C) && !rise_s;

    // Next-state logic: counters, measurement FSM and output registers.
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        locked_d     = locked_q;
        stuck_d      = stuck_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;

        if (rise_s) begin
            period_cnt_d = ONE_C;
            high_cnt_d   = ONE_C;
        end else begin
            period_cnt_d = sat_inc(period_cnt_q);
            if (s2_s) begin
                high_cnt_d = sat_inc(high_cnt_q);
            end else begin
                high_cnt_d = high_cnt_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_MEASURE: begin
                if (rise_s) begin
                    if (state_q == ST_MEASURE) begin
                        period_d = period_cnt_q;
                        duty_d   = clamp_duty(high_cnt_q);
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                    state_d = ST_MEASURE;
                end else if (timeout_s) begin
                    state_d  = ST_STUCK;
                    period_d = TIMEOUT_C;
                    duty_d   = s2_s ? DUTY_FULL : {W{1'b0}};
                    valid_d  = 1'b1;
                    locked_d = 1'b0;
                    stuck_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_STUCK: begin
                if (rise_s) begin
                    state_d = ST_MEASURE;
                    stuck_d = 1'b0;
                end else if (fall_s) begin
                    // The line left its static level low; count from this edge.
                    state_d      = ST_IDLE;
                    stuck_d      = 1'b0;
                    period_cnt_d = ONE_C;
                end else begin
                    state_d = ST_STUCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared immediately by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            s3_q         <= 1'b0;
            period_cnt_q <= {PW{1'b0}};
            high_cnt_q   <= {PW{1'b0}};
            duty_q       <= {W{1'b0}};
            period_q     <= {PW{1'b0}};
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            s3_q         <= s2_s;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
            stuck_q      <= stuck_d;
        end
    end

    assign duty         = duty_q;
    assign period       = period_q;
    assign sample_valid = valid_q;
    assign locked       = locked_q;
    assign stuck        = stuck_q;

endmodule : pwm_decoder

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: per-cycle input waveforms are scored against an
// event model that derives samples from rise/fall positions in the waveform.
module tb_pwm_decoder;

    localparam int PI   = 1200;
    localparam int TO   = 2400;
    localparam int DMAX = 2047;
    localparam int MAXN = 16000;

    typedef struct packed {
        int   edge_n;
        int   duty_v;
        int   period_v;
        logic locked_v;
        logic stuck_v;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_in;
    logic [10:0] duty;
    logic [11:0] period;
    logic        sample_valid;
    logic        locked;
    logic        stuck;

    int   checks   = 0;
    int   failures = 0;
    int   lv[0:MAXN];
    smp_t exp_q[$];
    smp_t obs_q[$];
    logic exp_locked;
    logic exp_stuck;

    pwm_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .duty         (duty),
        .period       (period),
        .sample_valid (sample_valid),
        .locked       (locked),
        .stuck        (stuck)
    );

    always #5 clk = ~clk;

    task automatic put(inout int pos, input int level, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            if (pos < MAXN) begin
                pos++;
                lv[pos] = level;
            end
        end
    endtask

    task automatic gen_pwm(inout int pos, input int value, input int periods);
        for (int p = 0; p < periods; p++) begin
            put(pos, 1, value);
            put(pos, 0, PI - value);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        #2;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Drive lv[1..n] one value per edge and log every strobe with its edge index.
    task automatic drive(input int n);
        obs_q.delete();
        for (int e = 1; e <= n; e++) begin
            pwm_in = lv[e][0];
            @(posedge clk);
            #1;
            if (sample_valid) begin
                obs_q.push_back('{e, int'(duty), int'(period), locked, stuck});
            end
        end
    endtask

    // Expected strobes from the waveform: a strobe appears two edges after
    // the input value that caused it.
    task automatic build_model(input int n);
        int   mode;
        int   ref_i;
        int   ones;
        logic lk;
        logic st;
        logic is_rise;
        logic is_fall;
        mode  = 0;
        ref_i = -1;
        lk    = 1'b0;
        st    = 1'b0;
        exp_locked = 1'b0;
        exp_stuck  = 1'b0;
        exp_q.delete();
        for (int i = 1; i <= n; i++) begin
            is_rise = (lv[i] == 1) && (lv[i-1] == 0);
            is_fall = (lv[i] == 0) && (lv[i-1] == 1);
            if (is_rise) begin
                if (mode == 1) begin
                    ones = 0;
                    for (int j = ref_i; j < i; j++) ones += lv[j];
                    exp_q.push_back('{i + 2, (ones > DMAX) ? DMAX : ones, i - ref_i, 1'b1, 1'b0});
                    lk = 1'b1;
                end
                st    = 1'b0;
                mode  = 1;
                ref_i = i;
            end else if (mode != 2 && (i - ref_i) == TO) begin
                exp_q.push_back('{i + 2, (lv[i] == 1) ? PI : 0, TO, 1'b0, 1'b1});
                lk   = 1'b0;
                st   = 1'b1;
                mode = 2;
            end else if (is_fall && mode == 2) begin
                mode  = 0;
                st    = 1'b0;
                ref_i = i;
            end
            if (i == n - 2) begin
                exp_locked = lk;
                exp_stuck  = st;
            end
        end
        while (exp_q.size() > 0 && exp_q[$].edge_n > n) void'(exp_q.pop_back());
    endtask

    task automatic test_reset();
        int pos;
        checks++;
        if ({duty, period, sample_valid, locked, stuck} !== 26'd0) begin
            failures++;
            $display("FAIL reset_init: got duty=%0d period=%0d valid=%0b locked=%0b stuck=%0b, expected all 0",
                     duty, period, sample_valid, locked, stuck);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pos = 0;
        lv[0] = 0;
        put(pos, 0, $urandom_range(1, 400));
        gen_pwm(pos, 300, 2);
        put(pos, 1, 150);
        drive(pos);
        build_model(pos);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL reset_run_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL reset_run_sample%0d: got edge=%0d duty=%0d period=%0d lk=%0b st=%0b, expected edge=%0d duty=%0d period=%0d lk=%0b st=%0b",
                         k, obs_q[k].edge_n, obs_q[k].duty_v, obs_q[k].period_v, obs_q[k].locked_v, obs_q[k].stuck_v,
                         exp_q[k].edge_n, exp_q[k].duty_v, exp_q[k].period_v, exp_q[k].locked_v, exp_q[k].stuck_v);
            end
        end
        // Mid-period asynchronous reset: outputs must clear without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (duty !== 11'd0 || period !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_meas: got duty=%0d period=%0d, expected 0 0", duty, period);
        end
        checks++;
        if ({sample_valid, locked, stuck} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_flags: got valid=%0b locked=%0b stuck=%0b, expected 0 0 0",
                     sample_valid, locked, stuck);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_steady_pwm();
        int pos;
        int n300;
        pos = 0;
        lv[0] = 0;
        put(pos, 0, $urandom_range(1, 1199));
        gen_pwm(pos, 300, 4);
        gen_pwm(pos, 900, 4);
        do_reset();
        drive(pos);
        build_model(pos);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL steady_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL steady_sample%0d: got edge=%0d duty=%0d period=%0d lk=%0b, expected edge=%0d duty=%0d period=%0d lk=%0b",
                         k, obs_q[k].edge_n, obs_q[k].duty_v, obs_q[k].period_v, obs_q[k].locked_v,
                         exp_q[k].edge_n, exp_q[k].duty_v, exp_q[k].period_v, exp_q[k].locked_v);
            end
        end
        n300 = 0;
        foreach (obs_q[k]) if (obs_q[k].duty_v == 300 && obs_q[k].period_v == PI && obs_q[k].locked_v) n300++;
        checks++;
        if (n300 != 4) begin
            failures++;
            $display("FAIL steady_300: got %0d samples duty=300 period=1200, expected 4", n300);
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[$].duty_v != 900 || obs_q[$].period_v != PI || obs_q[$].locked_v !== 1'b1) begin
            failures++;
            $display("FAIL steady_900: last sample wrong (strobes=%0d), expected duty=900 period=1200 locked=1", obs_q.size());
        end
    endtask

    task automatic test_static();
        int   pos;
        int   nstk;
        smp_t want;
        pos = 0;
        lv[0] = 0;
        put(pos, 0, 3000);
        do_reset();
        drive(pos);
        want = '{2401, 0, TO, 1'b0, 1'b1};
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== want) begin
            failures++;
            $display("FAIL static_zero: got %0d strobes (first edge=%0d duty=%0d period=%0d st=%0b), expected one at edge=2401 duty=0 period=2400 st=1",
                     obs_q.size(), obs_q.size() > 0 ? obs_q[0].edge_n : -1, obs_q.size() > 0 ? obs_q[0].duty_v : -1,
                     obs_q.size() > 0 ? obs_q[0].period_v : -1, obs_q.size() > 0 ? obs_q[0].stuck_v : 1'b0);
        end
        checks++;
        if (stuck !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL static_zero_flags: got stuck=%0b locked=%0b, expected 1 0", stuck, locked);
        end
        pos = 0;
        put(pos, 0, 100);
        gen_pwm(pos, 300, 2);
        put(pos, 1, 3000);
        put(pos, 0, 50);
        gen_pwm(pos, 200, 2);
        put(pos, 1, 200);
        put(pos, 0, 200);
        do_reset();
        drive(pos);
        build_model(pos);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL high_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL high_sample%0d: got edge=%0d duty=%0d period=%0d lk=%0b st=%0b, expected edge=%0d duty=%0d period=%0d lk=%0b st=%0b",
                         k, obs_q[k].edge_n, obs_q[k].duty_v, obs_q[k].period_v, obs_q[k].locked_v, obs_q[k].stuck_v,
                         exp_q[k].edge_n, exp_q[k].duty_v, exp_q[k].period_v, exp_q[k].locked_v, exp_q[k].stuck_v);
            end
        end
        nstk = 0;
        foreach (obs_q[k]) if (obs_q[k].stuck_v && obs_q[k].duty_v == PI && obs_q[k].period_v == TO) nstk++;
        checks++;
        if (nstk != 1) begin
            failures++;
            $display("FAIL high_stuck: got %0d stuck samples with duty=1200, expected 1", nstk);
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[$].duty_v != 200 || obs_q[$].period_v != PI || obs_q[$].locked_v !== 1'b1) begin
            failures++;
            $display("FAIL high_relock: last sample wrong (strobes=%0d), expected duty=200 period=1200 locked=1", obs_q.size());
        end
        checks++;
        if ({locked, stuck} !== {exp_locked, exp_stuck}) begin
            failures++;
            $display("FAIL high_flags: got locked=%0b stuck=%0b, expected %0b %0b", locked, stuck, exp_locked, exp_stuck);
        end
    endtask

    task automatic test_timeout_boundary();
        int   pos;
        smp_t want0;
        smp_t want1;
        pos = 0;
        lv[0] = 0;
        put(pos, 0, 10);
        put(pos, 1, 100);
        put(pos, 0, 2300);
        put(pos, 1, 100);
        put(pos, 0, 2301);
        put(pos, 1, 100);
        put(pos, 0, 500);
        do_reset();
        drive(pos);
        want0 = '{2413, 100, TO, 1'b1, 1'b0};
        want1 = '{4813, 0, TO, 1'b0, 1'b1};
        checks++;
        if (obs_q.size() != 2) begin
            failures++;
            $display("FAIL boundary_count: got %0d strobes, expected 2", obs_q.size());
        end
        checks++;
        if (obs_q.size() < 1 || obs_q[0] !== want0) begin
            failures++;
            $display("FAIL boundary_rise_wins: got edge=%0d duty=%0d period=%0d st=%0b, expected edge=2413 duty=100 period=2400 st=0",
                     obs_q.size() > 0 ? obs_q[0].edge_n : -1, obs_q.size() > 0 ? obs_q[0].duty_v : -1,
                     obs_q.size() > 0 ? obs_q[0].period_v : -1, obs_q.size() > 0 ? obs_q[0].stuck_v : 1'b0);
        end
        checks++;
        if (obs_q.size() < 2 || obs_q[1] !== want1) begin
            failures++;
            $display("FAIL boundary_timeout: got edge=%0d duty=%0d period=%0d st=%0b, expected edge=4813 duty=0 period=2400 st=1",
                     obs_q.size() > 1 ? obs_q[1].edge_n : -1, obs_q.size() > 1 ? obs_q[1].duty_v : -1,
                     obs_q.size() > 1 ? obs_q[1].period_v : -1, obs_q.size() > 1 ? obs_q[1].stuck_v : 1'b0);
        end
        checks++;
        if (stuck !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL boundary_flags: got stuck=%0b locked=%0b, expected 0 0", stuck, locked);
        end
    endtask

    task automatic test_random();
        int pos;
        pos = 0;
        lv[0] = 0;
        put(pos, 0, $urandom_range(1, 50));
        while (pos < MAXN - 3000) begin
            put(pos, 1, ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 2600) : $urandom_range(1, 800));
            put(pos, 0, ($urandom_range(0, 9) == 0) ? $urandom_range(2300, 2700) : $urandom_range(1, 1500));
        end
        put(pos, 0, 10);
        do_reset();
        drive(pos);
        build_model(pos);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                failures++;
                $display("FAIL random_sample%0d: got edge=%0d duty=%0d period=%0d lk=%0b st=%0b, expected edge=%0d duty=%0d period=%0d lk=%0b st=%0b",
                         k, obs_q[k].edge_n, obs_q[k].duty_v, obs_q[k].period_v, obs_q[k].locked_v, obs_q[k].stuck_v,
                         exp_q[k].edge_n, exp_q[k].duty_v, exp_q[k].period_v, exp_q[k].locked_v, exp_q[k].stuck_v);
            end
        end
        checks++;
        if ({locked, stuck} !== {exp_locked, exp_stuck}) begin
            failures++;
            $display("FAIL random_flags: got locked=%0b stuck=%0b, expected %0b %0b", locked, stuck, exp_locked, exp_stuck);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        test_reset();
        test_steady_pwm();
        test_static();
        test_timeout_boundary();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pwm_decoder

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, nominal PWM period in clk cycles (100 us at 12 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 2*PWM_INTERVAL, cycles without a rising edge before the line is declared static.
REQ-003 SHALL use derived widths W = $clog2(PWM_INTERVAL) and PW = $clog2(TIMEOUT+1).
REQ-004 SHALL expose: clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL expose: rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL expose: pwm_in  input  1  asynchronous PWM line, e.g. the output of the pwm generator.
REQ-007 SHALL expose: duty  output  W  measured high time in cycles.
REQ-008 SHALL expose: period  output  PW  measured rising-to-rising interval in cycles.
REQ-009 SHALL expose: sample_valid  output  1  one-cycle strobe; duty and period updated this cycle.
REQ-010 SHALL expose: locked  output  1  high while at least one full period has been measured and no timeout has occurred since.
REQ-011 SHALL expose: stuck  output  1  high while the line is static (timeout state).

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer, then a third flop for edge detection; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 SHALL implement states IDLE, MEASURE and STUCK.
REQ-014 SHALL use period_cnt and high_cnt (PW bits each), both saturating at TIMEOUT.
REQ-015 On a rise cycle, SHALL load period_cnt = 1 and high_cnt = 1; otherwise period_cnt += 1, and high_cnt += 1 only when s2 = 1.
REQ-016 Transition IDLE -> MEASURE on rise; no sample is produced.
REQ-017 In MEASURE, on rise SHALL register period = period_cnt and duty = min(high_cnt, 2^W-1), pulse sample_valid and set locked; the state stays MEASURE.
REQ-018 Transition IDLE or MEASURE -> STUCK when period_cnt == TIMEOUT without a rise; this SHALL pulse sample_valid with period = TIMEOUT, duty = 0 if s2 = 0 else min(PWM_INTERVAL, 2^W-1), locked = 0 and stuck = 1.
REQ-019 Transition STUCK -> MEASURE on rise, clearing stuck; no sample is produced.
REQ-020 Transition STUCK -> IDLE on fall, clearing stuck and restarting period_cnt at 1.
REQ-021 If rise and the timeout condition occur in the same cycle, rise SHALL win.
REQ-022 duty, period, locked and stuck SHALL hold their values between updates.
REQ-023 Latency: with pwm_in sampled high first at clk edge k, sample_valid SHALL be high in the cycle following edge k+2.
REQ-024 A 0%/100% PWM input SHALL produce exactly one STUCK sample per entry into STUCK.

Reset
REQ-025 While rst_n = 0, all flops SHALL clear immediately: state IDLE, synchronizer 0, counters 0, duty 0, period 0, sample_valid 0, locked 0, stuck 0.
REQ-026 After a reset mid-operation, the first sample SHALL require two rises after rst_n deasserts.

Structure
REQ-027 Package pwm_pkg SHALL hold the state enum typedef and a default-interval constant (1200) shared with the pwm generator.
REQ-028 The synchronizer SHALL be a sub-module named sync_2ff; all other logic SHALL live in pwm_decoder.

Verification
REQ-029 pwm generator with pwm_value=300 drives pwm_in -> from the second period on, each sample gives duty=300, period=1200 and locked=1.
REQ-030 pwm_value=0 -> after 2400 idle cycles, one sample with duty=0, period=2400 and stuck=1; no further strobes.
REQ-031 pwm_in held high after a rise -> STUCK sample with duty=1200 and stuck=1; a later fall then rise re-enters MEASURE, and the next rise gives a valid sample.
REQ-032 pwm_value changed from 300 to 900 mid-stream -> exactly one period gives a transitional duty, then duty=900.
REQ-033 rst_n pulsed low mid-period -> all outputs are 0 within the same cycle; the first sample after release arrives at the second rise.
REQ-034 Rise injected on the exact cycle period_cnt reaches 2400 -> a normal sample with period=2400, and no STUCK entry.
